key_debounce: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 28 ++
 rtl/key_filter.sv | 129 ++++++++++++
 rtl/key_debounce.sv | 73 +++++++
 tb/tb_key_debounce.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared constants for the two-key debouncer: system clock, debounce window, output codes.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package key_debounce_pkg;

   // System clock frequency and debounce window; DB_CYCLES is derived from these.
   localparam int SYS_FRQ = 50_000_000;
   localparam int DB_MS   = 20;

   localparam int DB_CYCLES_DEF = SYS_FRQ / 1000 * DB_MS;

   // Encodings of the key_out bus as seen by the UART transmitter.
   localparam logic [1:0] KEY_OUT_NONE = 2'b00;
   localparam logic [1:0] KEY_OUT_K0   = 2'b01;
   localparam logic [1:0] KEY_OUT_K1   = 2'b10;

   // Stability counter width.  It only has to reach cycles-1, and it is kept
   // at least 1 bit wide so tiny windows still elaborate.
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/key_filter.sv
// Single-key conditioner: 2-flop synchroniser, bounce-rejecting FSM, one-cycle press strobe.
// Latency: press is high in the cycle after edge DB_CYCLES+2 from a falling key_raw.
// Backpressure: none; press is a fire-and-forget strobe.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   key_raw  raw asynchronous button, active-low
//   press    registered single-cycle strobe on each accepted press
module key_filter
   import key_debounce_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = cnt_width(DB_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic press
);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] PRESS_WAIT = 2'd1;
   localparam logic [1:0] DOWN       = 2'd2;
   localparam logic [1:0] REL_WAIT   = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       sync;
   logic             key_s;
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             press_nxt;
   logic             cnt_done;

   assign key_s    = sync[1];
   assign cnt_done = (cnt == CNT_LAST);

   // State register together with synchroniser, counter and strobe flops.
   // Synchroniser resets to 1 so a held key after reset is seen as a fresh
   // falling level and has to be qualified over a full window again.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= 2'b11;
         state <= IDLE;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], key_raw};
         state <= state_nxt;
         cnt   <= cnt_nxt;
         press <= press_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!key_s) begin
               state_nxt = PRESS_WAIT;
            end
         end
         PRESS_WAIT: begin
            if (key_s) begin
               state_nxt = IDLE;
            end else if (cnt_done) begin
               state_nxt = DOWN;
            end
         end
         DOWN: begin
            if (key_s) begin
               state_nxt = REL_WAIT;
            end
         end
         REL_WAIT: begin
            if (!key_s) begin
               state_nxt = DOWN;
            end else if (cnt_done) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Counter and strobe.  The counter is cleared on entry to either wait
   // state and exits at CNT_LAST, so it never wraps.  Release is silent.
   always_comb begin
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (!key_s) begin
               cnt_nxt = '0;
            end
         end
         PRESS_WAIT: begin
            if (!key_s) begin
               if (cnt_done) begin
                  press_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
         end
         DOWN: begin
            if (key_s) begin
               cnt_nxt = '0;
            end
         end
         REL_WAIT: begin
            if (key_s && !cnt_done) begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            cnt_nxt = '0;
         end
      endcase
   end

endmodule

// File: rtl/key_debounce.sv
// Two-key debouncer feeding the UART transmitter: one registered pulse per clean press, one-hot.
// Latency: key_out high in the cycle after edge DB_CYCLES+3; a deferred key-1 pulse one cycle later.
// Backpressure: none; a key-1 press colliding with key 0 is parked in pend1 and never dropped.
//
// Ports:
//   clk      system clock (SYS_FRQ)
//   rst      synchronous active-high reset
//   key_in   raw asynchronous buttons, active-low
//   key_out  registered press pulses, active-high, at most one bit set per cycle
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = cnt_width(DB_CYCLES)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] key_in,
   output logic [1:0] key_out
);

   logic [1:0] press;
   logic       pend1;
   logic       pend1_nxt;
   logic [1:0] out_nxt;
   logic       want1;

   key_filter #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_key0 (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_in[0]),
      .press   (press[0])
   );

   key_filter #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_key1 (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_in[1]),
      .press   (press[1])
   );

   // Key 0 wins any collision; key 1 then waits in pend1 until the next free
   // cycle.  Two key-1 presses cannot both be outstanding because same-key
   // pulses are at least 2*DB_CYCLES+2 cycles apart.
   always_comb begin
      want1     = press[1] | pend1;
      out_nxt   = KEY_OUT_NONE;
      pend1_nxt = 1'b0;
      if (press[0]) begin
         out_nxt   = KEY_OUT_K0;
         pend1_nxt = want1;
      end else if (want1) begin
         out_nxt   = KEY_OUT_K1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_out <= KEY_OUT_NONE;
         pend1   <= 1'b0;
      end else begin
         key_out <= out_nxt;
         pend1   <= pend1_nxt;
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

   localparam int DB = 8;

   logic       clk;
   logic       rst;
   logic [1:0] key_in;
   logic [1:0] key_out;

   int total;
   int bad;
   int cyc;
   int p0;
   int p1;

   // Reference model state: synchronised samples, debounced level, run
   // lengths of consecutive low/high samples, accepted-press flags and the
   // number of key-1 pulses still owed to the output.
   bit         ms1 [2];
   bit         ms2 [2];
   bit         mdown [2];
   bit         macc [2];
   int         mlo [2];
   int         mhi [2];
   int         mpend;
   logic [1:0] mout;

   key_debounce #(.DB_CYCLES(DB)) dut (
      .clk     (clk),
      .rst     (rst),
      .key_in  (key_in),
      .key_out (key_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock edge of the reference.  A press is accepted after DB+1
   // consecutive low synchronised samples while released; a release after
   // DB+1 consecutive highs.  An accepted press shows on key_out one edge
   // later; key 0 first, key 1 whenever the output is free.
   task automatic model_edge();
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            ms1[k]   = 1'b1;
            ms2[k]   = 1'b1;
            mdown[k] = 1'b0;
            macc[k]  = 1'b0;
            mlo[k]   = 0;
            mhi[k]   = 0;
         end
         mpend = 0;
         mout  = 2'b00;
      end else begin
         if (macc[1]) mpend++;
         if (macc[0]) begin
            mout = 2'b01;
         end else if (mpend > 0) begin
            mout = 2'b10;
            mpend--;
         end else begin
            mout = 2'b00;
         end
         for (int k = 0; k < 2; k++) begin
            if (!ms2[k]) begin
               mlo[k]++;
               mhi[k] = 0;
            end else begin
               mhi[k]++;
               mlo[k] = 0;
            end
            macc[k] = 1'b0;
            if (!mdown[k] && mlo[k] >= DB + 1) begin
               mdown[k] = 1'b1;
               macc[k]  = 1'b1;
            end else if (mdown[k] && mhi[k] >= DB + 1) begin
               mdown[k] = 1'b0;
            end
            ms2[k] = ms1[k];
            ms1[k] = key_in[k];
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("key_out_vs_model", key_out, mout);
      chk("never_both", key_out == 2'b11, 0);
      if (key_out[0]) p0++;
      if (key_out[1]) p1++;
      cyc++;
   endtask

   initial begin
      int b0;
      int b1;
      int hold [2];

      total = 0;
      bad   = 0;
      cyc   = 0;
      p0    = 0;
      p1    = 0;
      mpend = 0;
      mout  = 2'b00;
      rst    = 1'b1;
      key_in = 2'b11;

      repeat (3) step();
      chk("reset_key_out", key_out, 2'b00);
      rst = 1'b0;
      repeat (20) step();

      // Clean press on key 0, then release.
      b0 = p0; b1 = p1;
      key_in[0] = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 10) chk("clean_before", key_out, 2'b00);
         if (i == 11) chk("clean_edge11", key_out, 2'b01);
         if (i == 12) chk("clean_single", key_out, 2'b00);
      end
      chk("clean_count", p0 - b0, 1);
      key_in[0] = 1'b1;
      b0 = p0;
      repeat (40) step();
      chk("release_silent", (p0 - b0) + (p1 - b1), 0);

      // Bounce on key 1, then a steady hold.
      b0 = p0; b1 = p1;
      for (int i = 0; i < 30; i++) begin
         key_in[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
         step();
      end
      chk("bounce_rejected", p1 - b1, 0);
      key_in[1] = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 11) chk("bounce_edge11", key_out, 2'b10);
      end
      chk("bounce_count", p1 - b1, 1);
      key_in[1] = 1'b1;
      repeat (40) step();

      // Simultaneous press: key 0 first, key 1 one cycle later.
      b0 = p0; b1 = p1;
      key_in = 2'b00;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 11) chk("simul_edge11", key_out, 2'b01);
         if (i == 12) chk("simul_edge12", key_out, 2'b10);
         if (i == 13) chk("simul_edge13", key_out, 2'b00);
      end
      chk("simul_count0", p0 - b0, 1);
      chk("simul_count1", p1 - b1, 1);
      key_in = 2'b11;
      repeat (40) step();

      // Release bounce: short high glitch while held down gives no new pulse.
      b0 = p0;
      key_in[0] = 1'b0;
      repeat (30) step();
      key_in[0] = 1'b1;
      repeat (5) step();
      key_in[0] = 1'b0;
      repeat (40) step();
      chk("rel_bounce_count", p0 - b0, 1);
      key_in[0] = 1'b1;
      repeat (40) step();

      // Reset five cycles into the press qualification.
      b0 = p0;
      key_in[0] = 1'b0;
      repeat (8) step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_mid_out", key_out, 2'b00);
      end
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 10) chk("reset_mid_before", key_out, 2'b00);
         if (i == 11) chk("reset_mid_edge11", key_out, 2'b01);
      end
      chk("reset_mid_count", p0 - b0, 1);
      key_in[0] = 1'b1;
      repeat (40) step();

      // Three repeat presses on key 0.
      b0 = p0; b1 = p1;
      repeat (3) begin
         key_in[0] = 1'b0;
         repeat (20) step();
         key_in[0] = 1'b1;
         repeat (20) step();
      end
      chk("repeat_count0", p0 - b0, 3);
      chk("repeat_count1", p1 - b1, 0);

      // Random bouncy traffic on both keys with occasional resets.
      hold[0] = 0;
      hold[1] = 0;
      for (int n = 0; n < 4000; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (hold[k] == 0) begin
               key_in[k] = ~key_in[k];
               hold[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(10, 30)
                                                     : $urandom_range(1, 6);
            end
            hold[k]--;
         end
         rst = ($urandom_range(0, 799) == 0);
         step();
      end
      rst = 1'b0;
      key_in = 2'b11;
      repeat (40) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
